// File: rtl/xrv_lsu_if.sv
// rtl/xrv_lsu_if.sv - execute-stage request/response and data-bus signals of the LSU
interface xrv_lsu_if #(
  parameter int DW = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [4:0]      req_dest;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic [4:0]      rsp_dest;
  logic            lsu_err;
  logic [31:0]     d_addr;
  logic            d_wr_req;
  logic            d_rd_req;
  logic [DW/8-1:0] d_be;
  logic [DW-1:0]   d_wr_data;
  logic            d_wr_ready;
  logic            d_rd_ready;
  logic [DW-1:0]   d_rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_dest,
    input  d_wr_ready, d_rd_ready, d_rd_data,
    output req_ready, rsp_valid, rsp_data, rsp_dest, lsu_err,
    output d_addr, d_wr_req, d_rd_req, d_be, d_wr_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_dest,
    output d_wr_ready, d_rd_ready, d_rd_data,
    input  req_ready, rsp_valid, rsp_data, rsp_dest, lsu_err,
    input  d_addr, d_wr_req, d_rd_req, d_be, d_wr_data
  );
endinterface

// File: rtl/xrv_lsu.sv
// rtl/xrv_lsu.sv - RV32I load/store unit: in-order store buffer, one bus access in flight
// Optional feature macro XRV_LSU_MISALIGN_EN: split word-crossing accesses into two beats.
module xrv_lsu #(
  parameter int DW       = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rstb,
  xrv_lsu_if.slave bus
);
  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int D2 = 2 * DW;
  localparam int B2 = 2 * NB;
  localparam logic [PW:0] SB_FULL = (PW+1)'(SB_DEPTH);

`ifdef XRV_LSU_MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RESP} state_e;

  function automatic logic [3:0] be_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // An access crosses when its last byte lands beyond the current bus word.
  function automatic logic crosses(input logic [31:0] a, input logic [2:0] f3);
    int last;
    last = int'(a[OB-1:0]) + ((f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4);
    return last > NB;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:OB], {OB{1'b0}}};
  endfunction

  // Enables/data over two consecutive words: low half is the first beat, high half the spill.
  function automatic logic [B2-1:0] lanes_be(input logic [31:0] a, input logic [2:0] f3);
    return B2'(be_of(f3)) << a[OB-1:0];
  endfunction

  function automatic logic [D2-1:0] lanes_data(input logic [31:0] a, input logic [2:0] f3,
                                               input logic [31:0] wd);
    logic [31:0] m;
    m = (f3[1:0] == 2'd0) ? 32'h0000_00FF : (f3[1:0] == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return D2'(wd & m) << {a[OB-1:0], 3'b000};
  endfunction

  state_e         state_q, state_d;
  logic [31:0]    d_addr_q, d_addr_d;
  logic [NB-1:0]  d_be_q, d_be_d;
  logic [DW-1:0]  d_wr_data_q, d_wr_data_d;
  logic           wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic           rsp_valid_q, rsp_valid_d, err_q, err_d, ready_en_q;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic [4:0]     rsp_dest_q, rsp_dest_d;
  logic [DW-1:0]  rd_lo_q, rd_lo_d;
  logic [31:0]    ld_addr_q, ld_addr_d;
  logic [2:0]     ld_f3_q, ld_f3_d;
  logic [4:0]     ld_dest_q, ld_dest_d;

  logic [31:0]    sb_addr_q [SB_DEPTH];
  logic [31:0]    sb_data_q [SB_DEPTH];
  logic [2:0]     sb_f3_q   [SB_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    cnt_q;

  logic           sb_empty, sb_full, req_bad, req_acc, push, ld_go, pop;
  logic [31:0]    hd_addr;
  logic [B2-1:0]  hd_be, rq_be, ld_be;
  logic [D2-1:0]  hd_data, rd_wide;
  logic           hd_split, ld_split;
  logic [31:0]    rd_raw, rd_ext;

  assign sb_empty = (cnt_q == '0);
  assign sb_full  = (cnt_q == SB_FULL);
  assign req_bad  = (bus.req_funct3 == 3'd3) || (bus.req_funct3[2] && bus.req_funct3[1]) ||
                    (bus.req_we && bus.req_funct3[2]) ||
                    (!SPLIT_EN && crosses(bus.req_addr, bus.req_funct3));
  assign bus.req_ready = ready_en_q && (bus.req_we ? !sb_full : (sb_empty && state_q == IDLE));
  assign req_acc  = bus.req_valid && bus.req_ready;
  assign push     = req_acc && bus.req_we && !req_bad;
  assign ld_go    = req_acc && !bus.req_we && !req_bad;

  assign hd_addr  = sb_addr_q[rd_ptr_q];
  assign hd_be    = lanes_be(hd_addr, sb_f3_q[rd_ptr_q]);
  assign hd_data  = lanes_data(hd_addr, sb_f3_q[rd_ptr_q], sb_data_q[rd_ptr_q]);
  assign hd_split = SPLIT_EN && crosses(hd_addr, sb_f3_q[rd_ptr_q]);
  assign rq_be    = lanes_be(bus.req_addr, bus.req_funct3);
  assign ld_be    = lanes_be(ld_addr_q, ld_f3_q);
  assign ld_split = SPLIT_EN && crosses(ld_addr_q, ld_f3_q);

  // Merge beats (low word bytes first), shift the addressed bytes down and extend.
  always_comb begin
    rd_wide = (state_q == RD_HI) ? {bus.d_rd_data, rd_lo_q} : {{DW{1'b0}}, bus.d_rd_data};
    rd_raw  = 32'(rd_wide >> {ld_addr_q[OB-1:0], 3'b000});
    case (ld_f3_q)
      3'd0:    rd_ext = {{24{rd_raw[7]}}, rd_raw[7:0]};
      3'd1:    rd_ext = {{16{rd_raw[15]}}, rd_raw[15:0]};
      3'd4:    rd_ext = {24'd0, rd_raw[7:0]};
      3'd5:    rd_ext = {16'd0, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase
  end

  // Bus FSM next state and registered bus/response outputs.
  always_comb begin
    state_d     = state_q;
    d_addr_d    = d_addr_q;
    d_be_d      = d_be_q;
    d_wr_data_d = d_wr_data_q;
    wr_req_d    = wr_req_q;
    rd_req_d    = rd_req_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_dest_d  = rsp_dest_q;
    rd_lo_d     = rd_lo_q;
    ld_addr_d   = ld_addr_q;
    ld_f3_d     = ld_f3_q;
    ld_dest_d   = ld_dest_q;
    pop         = 1'b0;
    err_d       = req_acc && req_bad;
    case (state_q)
      IDLE: begin
        if (!sb_empty) begin
          state_d     = WR_LO;
          wr_req_d    = 1'b1;
          d_addr_d    = word_of(hd_addr);
          d_be_d      = hd_be[NB-1:0];
          d_wr_data_d = hd_data[DW-1:0];
        end else if (ld_go) begin
          state_d   = RD_LO;
          rd_req_d  = 1'b1;
          d_addr_d  = word_of(bus.req_addr);
          d_be_d    = rq_be[NB-1:0];
          ld_addr_d = bus.req_addr;
          ld_f3_d   = bus.req_funct3;
          ld_dest_d = bus.req_dest;
        end
      end
      WR_LO: begin
        if (bus.d_wr_ready) begin
          if (hd_split) begin
            state_d     = WR_HI;
            d_addr_d    = word_of(hd_addr) + 32'(NB);
            d_be_d      = hd_be[B2-1:NB];
            d_wr_data_d = hd_data[D2-1:DW];
          end else begin
            state_d  = IDLE;
            wr_req_d = 1'b0;
            pop      = 1'b1;
          end
        end
      end
      WR_HI: begin
        if (bus.d_wr_ready) begin
          state_d  = IDLE;
          wr_req_d = 1'b0;
          pop      = 1'b1;
        end
      end
      RD_LO, RD_HI: begin
        if (bus.d_rd_ready) begin
          if (state_q == RD_LO && ld_split) begin
            state_d  = RD_HI;
            d_addr_d = word_of(ld_addr_q) + 32'(NB);
            d_be_d   = ld_be[B2-1:NB];
            rd_lo_d  = bus.d_rd_data;
          end else begin
            state_d     = RESP;
            rd_req_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_ext;
            rsp_dest_d  = ld_dest_q;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, bus outputs and buffer pointers; reset drops every request and empties the buffer.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      d_addr_q    <= '0;
      d_be_q      <= '0;
      d_wr_data_q <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_dest_q  <= '0;
      err_q       <= 1'b0;
      ready_en_q  <= 1'b0;
      rd_lo_q     <= '0;
      ld_addr_q   <= '0;
      ld_f3_q     <= '0;
      ld_dest_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      d_addr_q    <= d_addr_d;
      d_be_q      <= d_be_d;
      d_wr_data_q <= d_wr_data_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_dest_q  <= rsp_dest_d;
      err_q       <= err_d;
      ready_en_q  <= 1'b1;
      rd_lo_q     <= rd_lo_d;
      ld_addr_q   <= ld_addr_d;
      ld_f3_q     <= ld_f3_d;
      ld_dest_q   <= ld_dest_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q       <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Buffer payload; entries beyond the count are never read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr_q[wr_ptr_q] <= bus.req_addr;
      sb_data_q[wr_ptr_q] <= bus.req_wdata;
      sb_f3_q[wr_ptr_q]   <= bus.req_funct3;
    end
  end

  assign bus.d_addr    = d_addr_q;
  assign bus.d_be      = d_be_q;
  assign bus.d_wr_data = d_wr_data_q;
  assign bus.d_wr_req  = wr_req_q;
  assign bus.d_rd_req  = rd_req_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_dest  = rsp_dest_q;
  assign bus.lsu_err   = err_q;
endmodule

// File: tb/tb_xrv_lsu.sv
// tb/tb_xrv_lsu.sv - randomized scoreboard bench for xrv_lsu against a byte-memory model
module tb_xrv_lsu;
  localparam int DW = 32;
  localparam int NB = DW / 8;
`ifdef XRV_LSU_MISALIGN_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct { logic [31:0] addr; logic [NB-1:0] be; logic [DW-1:0] data; } wbeat_t;
  typedef struct { logic [31:0] data; logic [4:0] dest; int cyc; } rsp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   wr_mode = 0;
  int   rd_mode = 0;
  bit   lat_chk = 1'b0;

  wbeat_t     wr_q[$];
  rsp_t       rsp_q[$];
  int         err_q[$];
  logic [7:0] refmem [int];
  logic [7:0] busmem [int];

  xrv_lsu_if #(.DW(DW)) bus ();
  xrv_lsu #(.DW(DW), .SB_DEPTH(4)) dut (.clk(clk), .rstb(rstb), .bus(bus));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dflt(input int a);
    return 8'((a * 37) ^ (a >> 3) ^ 90);
  endfunction
  function automatic logic [7:0] rd_ref(input int a);
    return refmem.exists(a) ? refmem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] rd_bus(input int a);
    return busmem.exists(a) ? busmem[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour of an accepted request, from byte-level rules.
  task automatic model_accept(input bit we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [4:0] dest);
    int sz, off, w, ln;
    bit legal;
    wbeat_t b0, b1;
    rsp_t r;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    off = int'(a % NB);
    if (!legal || (off + sz > NB && !SPLIT)) begin
      err_q.push_back(cyc + 1);
    end else if (we) begin
      b0.addr = a - 32'(off); b0.be = '0; b0.data = '0;
      b1.addr = b0.addr + NB; b1.be = '0; b1.data = '0;
      for (int i = 0; i < sz; i++) begin
        w = (off + i) / NB;
        ln = (off + i) % NB;
        refmem[int'(a) + i] = wd[8*i +: 8];
        if (w == 0) begin b0.be[ln] = 1'b1; b0.data[8*ln +: 8] = wd[8*i +: 8]; end
        else        begin b1.be[ln] = 1'b1; b1.data[8*ln +: 8] = wd[8*i +: 8]; end
      end
      wr_q.push_back(b0);
      if (b1.be != '0) wr_q.push_back(b1);
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rd_ref(int'(a) + i);
      if (f3 == 3'd0 && v[7])  v[31:8]  = '1;
      if (f3 == 3'd1 && v[15]) v[31:16] = '1;
      r.data = v; r.dest = dest; r.cyc = lat_chk ? cyc + 2 : -1;
      rsp_q.push_back(r);
    end
  endtask

  // Drive one request (called just after a rising edge) until it is accepted.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] dest);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd; bus.req_dest = dest;
    while (!acc && n < 300) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = 1'b1;
        model_accept(we, f3, a, wd, dest);
      end
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL issue_timeout actual=not-accepted required=accepted addr=%h", a);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || rsp_q.size() != 0 || err_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("drain_wr_q", 64'(wr_q.size()), 0);
    chk("drain_rsp_q", 64'(rsp_q.size()), 0);
    chk("drain_err_q", 64'(err_q.size()), 0);
  endtask

  // Bus slave: ready policy per mode (0 random, 1 low, 2 high) and read data from bus memory.
  task automatic responder();
    logic [DW-1:0] rdw;
    forever begin
      @(posedge clk); #1;
      bus.d_wr_ready = (wr_mode == 2) || (wr_mode == 0 && ($urandom % 3) != 0);
      bus.d_rd_ready = (rd_mode == 2) || (rd_mode == 0 && ($urandom % 3) != 0);
      for (int l = 0; l < NB; l++) rdw[8*l +: 8] = rd_bus(int'(bus.d_addr) + l);
      bus.d_rd_data = rdw;
    end
  endtask

  // Scoreboard side: pops expectations whenever the DUT presents a result.
  task automatic monitor();
    rsp_t r;
    wbeat_t b;
    int e;
    logic [DW-1:0] m;
    forever begin
      @(negedge clk);
      if (rstb) begin
        if (bus.d_wr_req || bus.d_rd_req) begin
          chk("bus_one_access", 64'(bus.d_wr_req && bus.d_rd_req), 0);
          chk("addr_aligned", 64'(bus.d_addr % NB), 0);
        end
        if (bus.rsp_valid) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            r = rsp_q.pop_front();
            chk("rsp_data", bus.rsp_data, r.data);
            chk("rsp_dest", bus.rsp_dest, r.dest);
            if (r.cyc >= 0) chk("rsp_latency", cyc, r.cyc);
          end
        end
        if (bus.lsu_err) begin
          if (err_q.size() == 0) chk("err_unexpected", 1, 0);
          else begin
            e = err_q.pop_front();
            chk("err_cycle", cyc, e);
          end
        end
        if (bus.d_wr_req && bus.d_wr_ready) begin
          if (wr_q.size() == 0) chk("wr_unexpected", 64'(bus.d_addr), 64'hFFFF_FFFF);
          else begin
            b = wr_q.pop_front();
            for (int l = 0; l < NB; l++) m[8*l +: 8] = {8{b.be[l]}};
            chk("wr_addr", bus.d_addr, b.addr);
            chk("wr_be", 64'(bus.d_be), 64'(b.be));
            chk("wr_data", 64'(bus.d_wr_data & m), 64'(b.data));
          end
          for (int l = 0; l < NB; l++)
            if (bus.d_be[l]) busmem[int'(bus.d_addr) + l] = bus.d_wr_data[8*l +: 8];
        end
      end
    end
  endtask

  initial begin
    bit we;
    logic [2:0] f3;
    int act;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_dest = '0;
    bus.d_wr_ready = 1'b0; bus.d_rd_ready = 1'b0; bus.d_rd_data = '0;
    busmem[32'h103] = 8'h80; refmem[32'h103] = 8'h80;
    fork
      responder();
      monitor();
    join_none

    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_requests", 64'({bus.d_wr_req, bus.d_rd_req, bus.rsp_valid, bus.lsu_err}), 0);
    chk("rst_bus_regs", 64'({bus.d_addr, bus.d_be}), 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    #1 chk("ready_before_edge", 64'(bus.req_ready), 0);
    @(negedge clk);
    chk("ready_after_rst", 64'(bus.req_ready), 1);
    @(posedge clk); #1;

    // Sign-extended byte load with bus ready immediately: two-cycle latency.
    rd_mode = 2; lat_chk = 1'b1;
    issue(1'b0, 3'd0, 32'h103, 32'd0, 5'd7);
    lat_chk = 1'b0; rd_mode = 0;
    drain();

    // Load after store to the same word waits for the write.
    issue(1'b1, 3'd2, 32'h200, 32'h1122_3344, 5'd0);
    issue(1'b0, 3'd2, 32'h200, 32'd0, 5'd9);
    // Word store across a word boundary: split beats or an error.
    issue(1'b1, 3'd2, 32'h102, 32'hAABB_CCDD, 5'd0);
    issue(1'b0, 3'd5, 32'h102, 32'd0, 5'd3);
    drain();

    // Full store buffer blocks a fifth store until the bus drains it.
    wr_mode = 1;
    for (int i = 0; i < 4; i++) issue(1'b1, 3'd2, 32'h120 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 5'd0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h130; bus.req_wdata = 32'hC0DE_0004;
    act = 0;
    repeat (8) begin @(negedge clk); if (bus.req_ready) act++; @(posedge clk); #1; end
    chk("sb_full_blocks", 64'(act), 0);
    wr_mode = 2;
    issue(1'b1, 3'd2, 32'h130, 32'hC0DE_0004, 5'd0);
    wr_mode = 0;
    drain();

    for (int k = 0; k < 250; k++) begin
      we = 1'($urandom % 2);
      if ($urandom % 5 == 0) f3 = 3'($urandom % 8);
      else begin
        case ($urandom % 5)
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2;
          3: f3 = we ? 3'd0 : 3'd4;
          default: f3 = we ? 3'd1 : 3'd5;
        endcase
      end
      issue(we, f3, 32'h100 + 32'($urandom % 64), $urandom, 5'($urandom));
      if ($urandom % 4 == 0) begin @(posedge clk); #1; end
    end
    drain();

    // Reset while a read is pending and two stores are buffered.
    rd_mode = 1; wr_mode = 1;
    issue(1'b0, 3'd2, 32'h130, 32'd0, 5'd4);
    issue(1'b1, 3'd2, 32'h134, 32'hDEAD_0001, 5'd0);
    issue(1'b1, 3'd2, 32'h138, 32'hDEAD_0002, 5'd0);
    @(negedge clk); #2;
    rstb = 1'b0;
    #1;
    chk("mid_rst_requests", 64'({bus.d_wr_req, bus.d_rd_req, bus.rsp_valid, bus.req_ready}), 0);
    chk("mid_rst_bus_regs", 64'({bus.d_addr, bus.d_be}), 0);
    wr_q.delete(); rsp_q.delete(); err_q.delete();
    refmem = busmem;
    repeat (2) @(posedge clk);
    wr_mode = 2; rd_mode = 2;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", 64'(bus.req_ready), 1);
    act = 0;
    repeat (20) begin @(negedge clk); if (bus.d_wr_req || bus.d_rd_req || bus.rsp_valid) act++; end
    chk("no_activity_after_rst", 64'(act), 0);
    @(posedge clk); #1;
    wr_mode = 0; rd_mode = 0;
    issue(1'b0, 3'd2, 32'h134, 32'd0, 5'd5);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xrv_lsu.md
XRV_LSU -- requirements
Module: xrv_lsu

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data-bus width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter SB_DEPTH, default 4, meaning store-buffer entries; power of two, 2..8.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rstb  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  execute stage presents a load/store.
REQ-006 req_ready  output  1  LSU accepts request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I size/sign code (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU).
REQ-009 req_addr  input  32  byte address (rs1+imm, already summed).
REQ-010 req_wdata  input  32  store data, LSB-aligned.
REQ-011 req_dest  input  5  load destination register index.
REQ-012 rsp_valid  output  1  one-cycle load-result pulse.
REQ-013 rsp_data  output  32  extended load result.
REQ-014 rsp_dest  output  5  echo of req_dest for the load.
REQ-015 lsu_err  output  1  one-cycle pulse on illegal funct3 or rejected misaligned access.
REQ-016 d_addr  output  32  bus address, low log2(DW/8) bits always zero.
REQ-017 d_wr_req / d_rd_req  output  1 each  bus write / read request.
REQ-018 d_be  output  DW/8  byte enables; d_wr_data  output  DW  lane-positioned store data.
REQ-019 d_wr_ready / d_rd_ready  input  1 each  bus handshake; d_rd_data  input  DW.

Function
REQ-020 Request SHALL be accepted only in a cycle with req_valid and req_ready both high.
REQ-021 Store SHALL enqueue into the in-order store buffer; req_ready for store = buffer not full (registered count; no enqueue at full even if same-cycle drain).
REQ-022 Load SHALL be accepted only when store buffer is empty and no load is outstanding; req_ready low otherwise.
REQ-023 Bus FSM states SHALL be IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RESP; one bus access in flight at any time.
REQ-024 IDLE->WR_LO when buffer non-empty; IDLE->RD_LO on accepted load; *_LO->*_HI when access crosses a DW/8 boundary and ready seen, else WR_LO->IDLE (pop) / RD_LO->RESP; WR_HI->IDLE (pop); RD_HI->RESP; RESP->IDLE.
REQ-025 d_*_req SHALL assert the cycle after state entry and hold, with stable address/be/data, until ready sampled high, then drop the next cycle.
REQ-026 Aligned load latency: acceptance at T, d_rd_ready high at T+1 gives rsp_valid at T+2.
REQ-027 Load extension SHALL follow funct3: bytes/halves sign- (0,1) or zero- (4,5) extended; split loads merge low beat bytes then high beat bytes.
REQ-028 d_be/d_wr_data SHALL place bytes at lane (addr mod DW/8), wrapping remainder into lane 0 of the next word on a split.
REQ-029 funct3 3, 6, 7 (or store with funct3 >= 3) SHALL pulse lsu_err one cycle after acceptance, no bus access, no rsp_valid.

Reset
REQ-030 rstb low SHALL immediately clear: req_ready=0, rsp_valid=0, lsu_err=0, d_wr_req=0, d_rd_req=0, d_addr=0, d_be=0, d_wr_data=0, FSM=IDLE, buffer count=0; in-flight accesses and buffered stores are discarded.
REQ-031 req_ready SHALL rise the first cycle after rstb deasserts.

Configuration
REQ-032 With macro XRV_LSU_MISALIGN_EN defined, boundary-crossing accesses SHALL split per REQ-024.
REQ-033 Without XRV_LSU_MISALIGN_EN, boundary-crossing accesses SHALL pulse lsu_err, perform no bus access and, for loads, produce no rsp_valid; WR_HI/RD_HI unreachable.

Verification
REQ-034 DW=32: LB addr 0x103, d_rd_data 0x80xxxxxx, ready next cycle -> rsp_data 0xFFFFFF80, rsp_valid at T+2.
REQ-035 SB_DEPTH=4, d_wr_ready held low, 5 back-to-back SW -> 4 accepted, req_ready low on 5th; release ready -> 4 writes in order, 5th then accepted.
REQ-036 SW 0x11223344 to 0x200, then LW 0x200 -> load waits for write completion, returns 0x11223344.
REQ-037 MISALIGN_EN, DW=32, SW 0xAABBCCDD to 0x102 -> beat1 addr 0x100 be 0xC data 0xCCDD0000, beat2 addr 0x104 be 0x3 data 0x0000AABB; without macro -> lsu_err pulse, no d_wr_req.
REQ-038 DW=64, LHU addr 0x206, lane data 0xBEEF -> rsp_data 0x0000BEEF, d_addr 0x200, d_be 0xC0.
REQ-039 rstb low during RD_LO with 2 stores buffered -> all requests drop same cycle, no rsp_valid, no writes after rstb rises.
